bram_queue_bank: RTL and testbench

- Bank of N_QUEUE independent circular FIFOs, one dual-port block RAM per queue. Each queue has its own head/tail pointers.
- Each stored word carries a lap-parity valid bit. A read word is integrity-checked against the expected lap without clearing memory between laps.
- Sits between the patch front end and the sorter merge stage. It gives per-queue enqueue/dequeue with full/empty status.
- Successor to the fixed 8-queue init-only bank: width, depth and count are parametrised, and it adds dequeue, data return and a sticky error state.

---
 rtl/bram_queue_bank.sv | 154 +++++++++++++++
 tb/tb_bram_queue_bank.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_queue_bank.sv
// Bank of N_QUEUE circular FIFOs, one dual-port BRAM per queue. Each stored word carries
// a lap bit, so data read back is checked against the expected lap without clearing RAM.
module bram_queue_bank #(
  parameter int DELAY     = 1,
  parameter int N_QUEUE   = 8,
  parameter int ADDR_SIZE = 10,
  parameter int DATA_SIZE = 20
) (
  input  logic                       CLK,
  input  logic                       RESET,
  output logic                       ready,
  output logic                       error,
  input  logic                       enq_val,
  input  logic [$clog2(N_QUEUE)-1:0] enq_q,
  input  logic [DATA_SIZE-1:0]       enq_data,
  output logic                       enq_ack,
  input  logic                       deq_req,
  input  logic [$clog2(N_QUEUE)-1:0] deq_q,
  output logic                       deq_ack,
  output logic                       deq_val,
  output logic [DATA_SIZE-1:0]       deq_data,
  output logic [$clog2(N_QUEUE)-1:0] deq_num,
  output logic [N_QUEUE-1:0]         full,
  output logic [N_QUEUE-1:0]         empty
);

  localparam int QW    = $clog2(N_QUEUE);
  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE-1:0] A_ONE = ADDR_SIZE'(1);
  localparam logic [ADDR_SIZE-1:0] A_MAX = {ADDR_SIZE{1'b1}};

  // DELAY only shapes simulation timing in older models; it has no hardware meaning here.
  if (DELAY < 0) begin : g_neg_delay
  end

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_READY = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t                 state_q;
  logic [ADDR_SIZE-1:0]   head_q [N_QUEUE];
  logic [ADDR_SIZE-1:0]   tail_q [N_QUEUE];
  logic [N_QUEUE-1:0]     wr_lap_q;
  logic [N_QUEUE-1:0]     rd_lap_q;
  logic [DATA_SIZE:0]     mem_q [N_QUEUE][DEPTH];
  logic [DATA_SIZE:0]     rd_word_q;
  logic                   rd_v_q;
  logic                   rd_exp_q;
  logic [QW-1:0]          rd_num_q;
  logic                   deq_val_q;
  logic [DATA_SIZE-1:0]   deq_data_q;
  logic [QW-1:0]          deq_num_q;

  logic [N_QUEUE-1:0]     full_s;
  logic [N_QUEUE-1:0]     empty_s;
  logic [N_QUEUE-1:0]     we_s;
  logic [DATA_SIZE:0]     wdata_s [N_QUEUE];
  logic                   enq_ack_s;
  logic                   deq_ack_s;
  logic                   lap_ok_s;

  always_comb begin
    for (int i = 0; i < N_QUEUE; i++) begin
      full_s[i]  = (head_q[i] + A_ONE) == tail_q[i];
      empty_s[i] = head_q[i] == tail_q[i];
    end
    enq_ack_s = (state_q == ST_READY) && enq_val && !full_s[enq_q];
    deq_ack_s = (state_q == ST_READY) && deq_req && !empty_s[deq_q];
    lap_ok_s  = rd_word_q[DATA_SIZE] == rd_exp_q;
  end

  // INIT sweeps every RAM in parallel with the current write lap; afterwards only the enqueue target writes.
  always_comb begin
    for (int i = 0; i < N_QUEUE; i++) begin
      if (RESET) begin
        we_s[i] = 1'b0;
      end else if (state_q == ST_INIT) begin
        we_s[i] = 1'b1;
      end else begin
        we_s[i] = enq_ack_s && (enq_q == QW'(i));
      end
      wdata_s[i] = (state_q == ST_INIT) ? {wr_lap_q[i], {DATA_SIZE{1'b0}}}
                                        : {wr_lap_q[i], enq_data};
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_QUEUE; i++) begin
      if (we_s[i]) begin
        mem_q[i][head_q[i]] <= wdata_s[i];
      end
    end
    if (deq_ack_s) begin
      rd_word_q <= mem_q[deq_q][tail_q[deq_q]];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_INIT;
      for (int i = 0; i < N_QUEUE; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
      end
      wr_lap_q   <= '0;
      rd_lap_q   <= '1;
      rd_v_q     <= 1'b0;
      rd_exp_q   <= 1'b0;
      rd_num_q   <= '0;
      deq_val_q  <= 1'b0;
      deq_data_q <= '0;
      deq_num_q  <= '0;
    end else begin
      for (int i = 0; i < N_QUEUE; i++) begin
        if (we_s[i]) begin
          head_q[i] <= head_q[i] + A_ONE;
          if (head_q[i] == A_MAX) wr_lap_q[i] <= ~wr_lap_q[i];
        end
      end
      if (deq_ack_s) begin
        tail_q[deq_q] <= tail_q[deq_q] + A_ONE;
        if (tail_q[deq_q] == A_MAX) rd_lap_q[deq_q] <= ~rd_lap_q[deq_q];
        rd_exp_q <= rd_lap_q[deq_q];
        rd_num_q <= deq_q;
      end
      rd_v_q <= deq_ack_s;
      // A lap mismatch means the slot was never written on this lap: drop the word and lock up.
      deq_val_q <= rd_v_q && lap_ok_s && (state_q == ST_READY);
      if (rd_v_q && lap_ok_s && (state_q == ST_READY)) begin
        deq_data_q <= rd_word_q[DATA_SIZE-1:0];
        deq_num_q  <= rd_num_q;
      end
      case (state_q)
        ST_INIT:  if (head_q[0] == A_MAX) state_q <= ST_READY;
        ST_READY: if (rd_v_q && !lap_ok_s) state_q <= ST_ERROR;
        ST_ERROR: state_q <= ST_ERROR;
        default:  state_q <= ST_INIT;
      endcase
    end
  end

  assign ready    = state_q == ST_READY;
  assign error    = state_q == ST_ERROR;
  assign enq_ack  = enq_ack_s;
  assign deq_ack  = deq_ack_s;
  assign deq_val  = deq_val_q;
  assign deq_data = deq_data_q;
  assign deq_num  = deq_num_q;
  assign full     = full_s;
  assign empty    = empty_s;

endmodule

// File: tb/tb_bram_queue_bank.sv
// Randomised bench for bram_queue_bank: a queue-per-FIFO model predicts acks, status and
// the two-cycle read return; a few literal expectations pin init timing and fault handling.
module tb_bram_queue_bank;
  localparam int NQ = 8, AW = 10, DW = 20, QW = 3;
  localparam int DEPTH = 1 << AW, CAP = DEPTH - 1;

  logic          CLK = 1'b0, RESET = 1'b1;
  logic          enq_val = 1'b0, deq_req = 1'b0;
  logic [QW-1:0] enq_q = '0, deq_q = '0;
  logic [DW-1:0] enq_data = '0;
  logic          ready, error, enq_ack, deq_ack, deq_val;
  logic [DW-1:0] deq_data;
  logic [QW-1:0] deq_num;
  logic [NQ-1:0] full, empty;

  bram_queue_bank #(.DELAY(1), .N_QUEUE(NQ), .ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .CLK(CLK), .RESET(RESET), .ready(ready), .error(error),
    .enq_val(enq_val), .enq_q(enq_q), .enq_data(enq_data), .enq_ack(enq_ack),
    .deq_req(deq_req), .deq_q(deq_q), .deq_ack(deq_ack), .deq_val(deq_val),
    .deq_data(deq_data), .deq_num(deq_num), .full(full), .empty(empty)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;

  // Model: contents of every FIFO; bit DW marks a word whose RAM copy was corrupted.
  logic [DW:0]   mq [NQ][$];
  int            mst = 0;            // 0 = init, 1 = ready, 2 = error
  bit            mvalid = 1'b0;
  int            icnt = 0;
  bit            s1v = 1'b0, s1bad = 1'b0, s2v = 1'b0;
  logic [DW-1:0] s1d = '0, s2d = '0;
  logic [QW-1:0] s1n = '0, s2n = '0;
  int            obs_cnt [NQ];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    bit            e_ready, e_enq, e_deq, next_err;
    logic [NQ-1:0] e_full, e_empty;
    logic [DW:0]   w;
    e_ready = (mst == 1);
    e_enq   = e_ready && enq_val && (mq[enq_q].size() < CAP);
    e_deq   = e_ready && deq_req && (mq[deq_q].size() > 0);
    for (int i = 0; i < NQ; i++) begin
      e_full[i]  = mq[i].size() == CAP;
      e_empty[i] = mq[i].size() == 0;
    end
    if (mvalid) begin
      chk("ready", ready, e_ready);
      chk("error", error, mst == 2);
      chk("enq_ack", enq_ack, e_enq);
      chk("deq_ack", deq_ack, e_deq);
      if (mst != 0) begin
        chk("full", full, e_full);
        chk("empty", empty, e_empty);
      end
      chk("deq_val", deq_val, s2v);
      if (s2v) begin
        chk("deq_data", deq_data, s2d);
        chk("deq_num", deq_num, s2n);
      end
    end
    if (deq_val) obs_cnt[deq_num]++;
    if (RESET) begin
      mvalid = 1'b1; mst = 0; icnt = 0; s1v = 1'b0; s2v = 1'b0;
      foreach (mq[i]) mq[i].delete();
    end else if (mvalid) begin
      s2v = s1v && (mst == 1) && !s1bad;
      s2d = s1d; s2n = s1n;
      next_err = s1v && s1bad && (mst == 1);
      s1v = e_deq;
      if (e_deq) begin
        w = mq[deq_q].pop_front();
        s1d = w[DW-1:0]; s1bad = w[DW]; s1n = deq_q;
      end
      if (e_enq) mq[enq_q].push_back({1'b0, enq_data});
      if (mst == 0) begin
        icnt++;
        if (icnt == DEPTH) mst = 1;
      end else if (next_err) begin
        mst = 2;
      end
    end
  end

  task automatic drive(input bit ev, input int eq, input logic [DW-1:0] ed, input bit dr, input int dq);
    enq_val = ev; enq_q = eq[QW-1:0]; enq_data = ed;
    deq_req = dr; deq_q = dq[QW-1:0];
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, '0, 1'b0, 0);
  endtask

  task automatic reset_and_wait(input bit pin_reset_values);
    int n;
    RESET = 1'b1;
    drive(1'b0, 0, '0, 1'b0, 0);
    RESET = 1'b0;
    chk("deq_val_after_reset", deq_val, 0);
    if (pin_reset_values) begin
      chk("reset_ready", ready, 0);
      chk("reset_error", error, 0);
      chk("reset_empty", empty, 8'hFF);
      chk("reset_full", full, 8'h00);
      chk("reset_deq_data", deq_data, 0);
      chk("reset_deq_num", deq_num, 0);
    end
    n = 0;
    while (!ready && n < 3000) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("init_cycles", n, DEPTH);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: still running at %0t, required finish before 3000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int            base, sent, n;
    logic [DW:0]   w;
    int            seq [3];
    seq[0] = 0; seq[1] = 5; seq[2] = 7;
    foreach (obs_cnt[i]) obs_cnt[i] = 0;
    RESET = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end
    reset_and_wait(1'b1);
    chk("ready_after_init_empty", empty, 8'hFF);
    chk("ready_after_init_full", full, 8'h00);

    // Fill queue 3 to capacity, then one refused enqueue.
    for (int k = 1; k <= CAP; k++) drive(1'b1, 3, DW'(k), 1'b0, 0);
    chk("fill_full", full, 8'h08);
    chk("fill_empty", empty, 8'hF7);
    enq_val = 1'b1; enq_q = 3'd3; enq_data = DW'(1024);
    #1 chk("enq_to_full_ack", enq_ack, 0);
    @(posedge CLK); #1;

    // Drain queue 3; the model checks order, deq_num and latency.
    base = obs_cnt[3];
    for (int k = 0; k < CAP; k++) drive(1'b0, 0, '0, 1'b1, 3);
    idle(3);
    chk("drain_count", obs_cnt[3] - base, CAP);
    chk("drain_empty", empty, 8'hFF);

    // Stream 3000 words through queue 0 at low occupancy, crossing the wrap twice.
    base = obs_cnt[0]; sent = 0; n = 0;
    while ((sent < 3000 || mq[0].size() > 0) && n < 20000) begin
      bit ev;
      ev = (sent < 3000) && (mq[0].size() < 5) && ($urandom_range(3) != 0);
      drive(ev, 0, DW'($urandom), 1'($urandom_range(1)), 0);
      if (ev) sent++;
      n++;
    end
    idle(3);
    chk("wrap_count", obs_cnt[0] - base, 3000);
    chk("wrap_error", error, 0);

    // Same-queue enqueue and dequeue every cycle at occupancy 1.
    drive(1'b1, 5, DW'($urandom), 1'b0, 0);
    for (int k = 0; k < 100; k++) drive(1'b1, 5, DW'($urandom), 1'b1, 5);
    chk("same_q_empty5", empty[5], 0);
    chk("same_q_full5", full[5], 0);
    drive(1'b0, 0, '0, 1'b1, 5);
    idle(3);

    // Interleaved dequeues across queues 0, 5, 7.
    for (int k = 0; k < 12; k++) drive(1'b1, seq[k % 3], DW'($urandom), 1'b0, 0);
    for (int k = 0; k < 12; k++) drive(1'b0, 0, '0, 1'b1, seq[k % 3]);
    idle(3);

    // Random traffic over all queues.
    for (int k = 0; k < 1500; k++)
      drive(1'($urandom_range(1)), $urandom_range(NQ - 1), DW'($urandom),
            1'($urandom_range(1)), $urandom_range(NQ - 1));
    idle(3);
    chk("random_error", error, 0);

    // Corrupt the lap bit of queue 2 address 0 and dequeue it.
    reset_and_wait(1'b0);
    for (int k = 0; k < 3; k++) drive(1'b1, 2, DW'(100 + k), 1'b0, 0);
    idle(1);
    w = dut.mem_q[2][0];
    chk("stored_lap", w[DW], 1);
    w[DW] = 1'b0;
    dut.mem_q[2][0] = w;
    mq[2][0][DW] = 1'b1;
    drive(1'b0, 0, '0, 1'b1, 2);
    idle(1);
    chk("fault_error", error, 1);
    chk("fault_ready", ready, 0);
    for (int k = 0; k < 5; k++) drive(1'b1, 2, DW'(7), 1'b1, 2);
    chk("fault_sticky", error, 1);

    // Reset with reads in flight, then INIT must rerun in full.
    reset_and_wait(1'b0);
    for (int k = 0; k < 4; k++) drive(1'b1, 1, DW'($urandom), 1'b0, 0);
    drive(1'b0, 0, '0, 1'b1, 1);
    drive(1'b0, 0, '0, 1'b1, 1);
    reset_and_wait(1'b0);
    chk("post_reset_error", error, 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
